// File: rtl/busmatrix_dphase_mux.sv
// AHB data-phase mux: captures a one-hot address-phase select on hready and steers that port's data to out_data.
// Latency: the select is held from N+1; out_data is valid in N+1, or N+2 with REG_OUT. Wait states hold the select, and multi-hot selects are flagged and counted.
module busmatrix_dphase_mux #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_OUT       = 0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                            hclk,
  input  logic                            hresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            addr_sel,
  input  logic                            hready,
  input  logic                            clr_err,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [NUM_PORTS-1:0]            dphase_sel,
  output logic                            dphase_active,
  output logic                            sel_err,
  output logic [ERR_CNT_WIDTH-1:0]        err_cnt
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

  logic                  multi_hot;
  logic [DATA_WIDTH-1:0] mux_val;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi_hot = |(addr_sel & (addr_sel - NUM_PORTS'(1)));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dphase_sel <= '0;
      sel_err    <= 1'b0;
    end else if (hready) begin
      dphase_sel <= multi_hot ? '0 : addr_sel;
      sel_err    <= multi_hot;
    end else begin
      sel_err    <= 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (hready && multi_hot && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign dphase_active = |dphase_sel;

  // AND-OR mux is safe because dphase_sel can never be multi-hot.
  always_comb begin
    mux_val = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      mux_val = mux_val | ({DATA_WIDTH{dphase_sel[k]}} & in_data[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_WIDTH-1:0] out_q;
      always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) out_q <= '0;
        else          out_q <= mux_val;
      end
      assign out_data = out_q;
    end else begin : g_comb_out
      assign out_data = mux_val;
    end
  endgenerate

endmodule
